// File: rtl/counter_pkg.sv
// counter_pkg: direction and end-mode types shared by the counter library
package counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_t;
endpackage

// File: rtl/counter_next.sv
// counter_next: next-count, wrap and overflow events for one enabled step
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_evt,
  output logic             ovf_evt
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic up, sat, at_end;
  always_comb begin
    up = dir_t'(up_dn) == DIR_UP;
    sat = mode_t'(sat_mode) == MODE_SAT;
    // >= keeps an out-of-range count behaving as if it sat at MAX
    at_end = up ? (count >= MAX) : (count == '0);
    nxt = at_end ? (sat ? (up ? MAX : '0) : (up ? '0 : MAX))
                 : (up ? count + 1'b1 : count - 1'b1);
    wrap_evt = at_end && !sat;
    ovf_evt = at_end;
  end
endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: synchronous up/down modulo counter with load, clear, wrap/saturate
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  if (WIDTH < 2 || MAX_VAL < 1 || longint'(MAX_VAL) > (longint'(1) << WIDTH) - 1)
    $error("updown_counter_mod: bad WIDTH/MAX_VAL");
  logic [WIDTH-1:0] nxt;
  logic wrap_evt, ovf_evt;
  counter_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_next (
    .count(count), .up_dn(up_dn), .sat_mode(sat_mode),
    .nxt(nxt), .wrap_evt(wrap_evt), .ovf_evt(ovf_evt)
  );
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      wrap <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX) ? MAX : load_val;
      wrap <= 1'b0;
    end else if (en) begin
      count <= nxt;
      wrap <= wrap_evt;
      ovf <= ovf | ovf_evt;
    end else begin
      wrap <= 1'b0;
    end
  end
  assign tc = (dir_t'(up_dn) == DIR_UP) ? (count == MAX) : (count == '0);
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: directed checks on a MAX_VAL=9 and a MAX_VAL=1 counter
module tb_updown_counter_mod;
  logic clk = 1'b0;
  logic rst, clr, en, up_dn, sat_mode, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic tc, wrap, ovf;
  logic [1:0] count2;
  logic tc2, wrap2, ovf2;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count), .tc(tc), .wrap(wrap), .ovf(ovf)
  );
  updown_counter_mod #(.WIDTH(2), .MAX_VAL(1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val[1:0]), .count(count2), .tc(tc2), .wrap(wrap2), .ovf(ovf2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {rst, clr, en, load, sat_mode} = '0;
    up_dn = 1'b1;
    load_val = '0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if ({count, wrap, ovf, tc} !== 7'b0) begin
      errs++;
      $display("FAIL reset_up count=%0d wrap=%b ovf=%b tc=%b want 0 0 0 0", count, wrap, ovf, tc);
    end
    up_dn = 1'b0;
    #1;
    vecs++;
    if (tc !== 1'b1) begin
      errs++;
      $display("FAIL reset_tc_down tc=%b want 1", tc);
    end
    up_dn = 1'b1;
  endtask

  task automatic test_up_wrap;
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      vecs++;
      if (count !== 4'(i % 10) || wrap !== (i == 10) || ovf !== (i == 10) || tc !== (i == 9)) begin
        errs++;
        $display("FAIL up_wrap step %0d count=%0d wrap=%b ovf=%b tc=%b want %0d %b %b %b",
                 i, count, wrap, ovf, tc, i % 10, i == 10, i == 10, i == 9);
      end
    end
    en = 1'b0;
    step();
    vecs++;
    if (wrap !== 1'b0 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL up_wrap_hold wrap=%b ovf=%b want 0 1", wrap, ovf);
    end
  endtask

  task automatic test_down_wrap;
    logic [3:0] exp [3] = '{4'd9, 4'd8, 4'd7};
    clr = 1'b1;
    step();
    clr = 1'b0;
    vecs++;
    if (count !== 4'd0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL clr count=%0d ovf=%b want 0 0", count, ovf);
    end
    up_dn = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (count !== exp[i] || wrap !== (i == 0) || ovf !== 1'b1) begin
        errs++;
        $display("FAIL down_wrap %0d count=%0d wrap=%b ovf=%b want %0d %b 1",
                 i, count, wrap, ovf, exp[i], i == 0);
      end
    end
    idle();
  endtask

  task automatic test_saturate;
    clr = 1'b1;
    step();
    clr = 1'b0;
    sat_mode = 1'b1;
    load = 1'b1;
    load_val = 4'd8;
    step();
    load = 1'b0;
    vecs++;
    if (count !== 4'd8 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL sat_load count=%0d ovf=%b want 8 0", count, ovf);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (count !== 4'd9 || wrap !== 1'b0 || ovf !== (i > 0)) begin
        errs++;
        $display("FAIL sat_up %0d count=%0d wrap=%b ovf=%b want 9 0 %b", i, count, wrap, ovf, i > 0);
      end
    end
    en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    up_dn = 1'b0;
    en = 1'b1;
    step();
    vecs++;
    if (count !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL sat_down count=%0d wrap=%b ovf=%b want 0 0 1", count, wrap, ovf);
    end
    idle();
  endtask

  task automatic test_load_clamp;
    clr = 1'b1;
    step();
    clr = 1'b0;
    load = 1'b1;
    en = 1'b1;
    load_val = 4'd15;
    step();
    vecs++;
    if (count !== 4'd9 || wrap !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL load_clamp count=%0d wrap=%b ovf=%b want 9 0 0", count, wrap, ovf);
    end
    idle();
  endtask

  task automatic test_clr_load_rst;
    en = 1'b1;
    step();
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd5;
    step();
    vecs++;
    if (count !== 4'd5 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL load_keeps_ovf count=%0d ovf=%b want 5 1", count, ovf);
    end
    clr = 1'b1;
    load_val = 4'd3;
    step();
    clr = 1'b0;
    vecs++;
    if (count !== 4'd0 || ovf !== 1'b0 || wrap !== 1'b0) begin
      errs++;
      $display("FAIL clr_over_load count=%0d ovf=%b wrap=%b want 0 0 0", count, ovf, wrap);
    end
    load_val = 4'd7;
    step();
    load = 1'b0;
    en = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if (count !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_count count=%0d wrap=%b ovf=%b want 0 0 0", count, wrap, ovf);
    end
    idle();
  endtask

  task automatic test_max1_and_dir;
    rst = 1'b1;
    step();
    rst = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      vecs++;
      if (count2 !== 2'(i % 2) || wrap2 !== (i % 2 == 0) || count !== 4'(i)) begin
        errs++;
        $display("FAIL max1_up %0d count2=%0d wrap2=%b count=%0d want %0d %b %0d",
                 i, count2, wrap2, count, i % 2, i % 2 == 0, i);
      end
    end
    up_dn = 1'b0;
    step();
    vecs++;
    if (count2 !== 2'd1 || wrap2 !== 1'b1 || count !== 4'd3 || tc !== 1'b0) begin
      errs++;
      $display("FAIL dir_flip count2=%0d wrap2=%b count=%0d tc=%b want 1 1 3 0", count2, wrap2, count, tc);
    end
    step();
    vecs++;
    if (count2 !== 2'd0 || wrap2 !== 1'b0 || tc2 !== 1'b1 || count !== 4'd2) begin
      errs++;
      $display("FAIL dir_down count2=%0d wrap2=%b tc2=%b count=%0d want 0 0 1 2", count2, wrap2, tc2, count);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_clr_load_rst();
    test_max1_and_dir();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
